instr_fetch_unit: RTL

- Front end of the 3-stage pipeline. Issues program-memory reads at the current PC and buffers the returned 16-bit instruction words in a small prefetch FIFO.
- Presents each word to the first control stage as segment[15:8]=opcode, segment[7:0]=operand, together with the next-PC value.
- Accepts PC redirects (jump, call, return) from the decode/execute control and squashes stale fetches.
- It is the producer end of the segment/PC interface that the decode stages consume.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_if.sv | 30 +++
 rtl/ifu_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding and the prefetch FIFO entry layout.
package ifu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_SEG = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } ifu_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] seg;
        logic [PC_W-1:0]    npc;
    } fifo_entry_t;

    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch unit bus: program-memory read port, redirect/stall control from
// decode, and the segment/next-PC output consumed by the decode stages.
interface ifu_if;
    import ifu_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    logic               load_pc;
    logic [PC_W-1:0]    pc_target;
    logic               stall;

    logic [INSTR_W-1:0] segment;
    logic               seg_valid;
    logic [PC_W-1:0]    npc;
    logic               fetch_err;

    modport master (
        output imem_req, imem_addr, segment, seg_valid, npc, fetch_err,
        input  imem_rdata, imem_ack, load_pc, pc_target, stall
    );

    modport slave (
        input  imem_req, imem_addr, segment, seg_valid, npc, fetch_err,
        output imem_rdata, imem_ack, load_pc, pc_target, stall
    );

endinterface

// File: rtl/ifu_fifo.sv
// Prefetch FIFO holding {instruction, next-PC} entries.
// Synchronous push/pop/flush; flush wins over push and pop in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fifo_entry_t            wdata_i,
    output fifo_entry_t            head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Storage needs no reset: nothing reads it while the count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC/FSM, program-memory handshake, prefetch FIFO.
// Optional IFU_ACK_TIMEOUT_EN: abandon and reissue a request unacked for TIMEOUT cycles.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
`ifdef IFU_ACK_TIMEOUT_EN
    ,
    parameter int              TIMEOUT  = 15
`endif
) (
    input  logic  clk,
    input  logic  rst_n,
    ifu_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] drop_addr_q, drop_addr_d;
    logic [PC_W-1:0] pc_inc;
    logic            req, ack, load, timeout;
    logic            push, pop, full, empty;
    logic [CW-1:0]   count, count_after;
    fifo_entry_t     push_data, head;

    assign ack    = bus.imem_ack;
    assign load   = bus.load_pc;
    assign req    = (state_q == REQ) || (state_q == DROP);
    assign pc_inc = pc_incr(pc_q);

    // A redirect cancels both ends of the FIFO in the same cycle.
    assign push        = (state_q == REQ) && ack && !load;
    assign pop         = !empty && !bus.stall && !load;
    assign push_data   = '{seg: bus.imem_rdata, npc: pc_inc};
    assign count_after = count + CW'(push) - CW'(pop);

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (load),
        .wdata_i (push_data),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        unique case (state_q)
            IDLE: begin
                if (load || !full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (load) begin
                    // Request can't be withdrawn; keep it at the old address and discard its data.
                    if (!ack) begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (ack) begin
                    pc_d = pc_inc;
                    if (count_after == CW'(DEPTH)) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pc_d = bus.pc_target;
        end
        if (timeout) begin
            if (state_q == REQ) begin
                state_d = IDLE;
            end else if (state_q == DROP) begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

`ifdef IFU_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q;
    logic          fetch_err_q;

    assign timeout = req && !ack && (to_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            if (!req || ack || timeout) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timeout) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign bus.fetch_err = fetch_err_q;
`else
    assign timeout       = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign bus.seg_valid = !empty;
    assign bus.segment   = empty ? NOP_SEG : head.seg;
    assign bus.npc       = empty ? '0 : head.npc;

endmodule
